nibble_word_assembler: RTL

- Pop-side consumer placed directly downstream of different_widths_fifo.
- Drains the narrow IN_WIDTH nibble stream from the FIFO, first nibble into the least-significant slot, and packs it into OUT_WIDTH words.
- Presents each word on a valid/ready output port.
- A flush request emits a zero-padded partial word so that trailing nibbles are not stranded.

---
 rtl/nibble_pkg.sv | 28 ++
 rtl/nibble_word_assembler_if.sv | 35 +++
 rtl/nibble_word_assembler.sv | 102 ++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-to-word assembler:
// default widths, derived sizes and elaboration-time helpers.
package nibble_pkg;

   localparam int IN_W_DEF  = 4;
   localparam int OUT_W_DEF = 16;
   localparam int CNT_W_DEF = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int idx_width(input int n);
      return (clog2(n) > 0) ? clog2(n) : 1;
   endfunction

   function automatic bit width_ok(input int iw, input int ow);
      return (iw > 0) && (ow >= iw) && ((ow % iw) == 0);
   endfunction

   localparam int NIBBLES_PER_WORD = OUT_W_DEF / IN_W_DEF;
   localparam int IDX_WIDTH        = idx_width(NIBBLES_PER_WORD);
   localparam bit WIDTH_OK         = width_ok(IN_W_DEF, OUT_W_DEF);

endpackage

// File: rtl/nibble_word_assembler_if.sv
// FIFO pop side and word output side of the assembler.
// master is the assembler, slave is its environment.
interface nibble_word_assembler_if
   import nibble_pkg::*;
#(
   parameter int IN_WIDTH  = IN_W_DEF,
   parameter int OUT_WIDTH = OUT_W_DEF,
   parameter int CNT_WIDTH = CNT_W_DEF
);
   localparam int NB_WIDTH = clog2(OUT_WIDTH / IN_WIDTH) + 1;

   logic [IN_WIDTH-1:0]  fifo_q;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic                 flush;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_partial;
   logic [NB_WIDTH-1:0]  out_nibbles;
   logic [CNT_WIDTH-1:0] word_count;

   modport master (
      input  fifo_q, fifo_empty, flush, out_ready,
      output fifo_pop, out_data, out_valid, out_partial,
      output out_nibbles, word_count
   );

   modport slave (
      output fifo_q, fifo_empty, flush, out_ready,
      input  fifo_pop, out_data, out_valid, out_partial,
      input  out_nibbles, word_count
   );

endinterface

// File: rtl/nibble_word_assembler.sv
// Drains a narrow FIFO, packs nibbles LSB-first into words,
// and emits zero-padded partial words on flush.
module nibble_word_assembler
   import nibble_pkg::*;
#(
   parameter int IN_WIDTH  = IN_W_DEF,
   parameter int OUT_WIDTH = OUT_W_DEF,
   parameter int CNT_WIDTH = CNT_W_DEF
) (
   input logic clk,
   input logic rst,
   nibble_word_assembler_if.master bus
);
   localparam int N  = OUT_WIDTH / IN_WIDTH;
   localparam int IW = idx_width(N);
   localparam int NW = clog2(N) + 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   if (!width_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_width
      $error("OUT_WIDTH must be a multiple of IN_WIDTH");
   end

   typedef logic [N-1:0][IN_WIDTH-1:0] word_t;

   word_t                collect;
   word_t                full_word;
   word_t                part_word;
   logic [IW-1:0]        k;
   logic                 pending;
   logic                 pend_nxt;
   logic                 slot_free;
   logic                 pop;
   logic                 emit_full;
   logic                 emit_part;
   logic [OUT_WIDTH-1:0] data_q;
   logic                 valid_q;
   logic                 partial_q;
   logic [NW-1:0]        nib_q;
   logic [CNT_WIDTH-1:0] count_q;

   always_comb begin
      slot_free = !valid_q || bus.out_ready;
      pop = rst && !bus.fifo_empty && !bus.flush && !pending
         && !((k == LAST) && !slot_free);
      emit_full = pop && (k == LAST);
      emit_part = pending && slot_free && (k != '0);
      // a pending flush survives only while a partial word is blocked
      pend_nxt = pending ? ((k != '0) && !slot_free) : bus.flush;
      full_word = collect;
      full_word[k] = bus.fifo_q;
      part_word = '0;
      for (int i = 0; i < N; i++) begin
         if (i < int'(k)) part_word[i] = collect[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         collect   <= '0;
         k         <= '0;
         pending   <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         partial_q <= 1'b0;
         nib_q     <= '0;
         count_q   <= '0;
      end else begin
         pending <= pend_nxt;
         if (pop) begin
            collect[k] <= bus.fifo_q;
            k <= (k == LAST) ? '0 : k + 1'b1;
         end
         if (emit_part) begin
            collect <= '0;
            k       <= '0;
         end
         if (valid_q && bus.out_ready) begin
            count_q <= count_q + 1'b1;
            valid_q <= 1'b0;
         end
         if (emit_full) begin
            data_q    <= full_word;
            valid_q   <= 1'b1;
            partial_q <= 1'b0;
            nib_q     <= NW'(N);
         end else if (emit_part) begin
            data_q    <= part_word;
            valid_q   <= 1'b1;
            partial_q <= 1'b1;
            nib_q     <= NW'(k);
         end
      end
   end

   assign bus.fifo_pop    = pop;
   assign bus.out_data    = data_q;
   assign bus.out_valid   = valid_q;
   assign bus.out_partial = partial_q;
   assign bus.out_nibbles = nib_q;
   assign bus.word_count  = count_q;

endmodule
